// File: rtl/ps2_event_queue_pkg.sv
// Shared definitions for the PS/2 event queue: bus addresses, entry layout, status layout.
package ps2_event_queue_pkg;

    // Default ZX-UNO register addresses
    localparam logic [7:0] QDATA_ADDR_DEF   = 8'h0A;
    localparam logic [7:0] QSTATUS_ADDR_DEF = 8'h0B;

    // Queue entry layout: {chan[1:0], released, extended, scancode[7:0]}
    localparam int unsigned ENTRY_W  = 12;
    localparam int unsigned SC_LSB   = 0;
    localparam int unsigned EXT_BIT  = 8;
    localparam int unsigned RLS_BIT  = 9;
    localparam int unsigned CHAN_LSB = 10;

    // Status register bit positions
    localparam int unsigned ST_NEMPTY   = 7;
    localparam int unsigned ST_OVF      = 6;
    localparam int unsigned ST_RLS      = 5;
    localparam int unsigned ST_EXT      = 4;
    localparam int unsigned ST_CHAN_LSB = 2;
    localparam int unsigned ST_FULL     = 1;

    // Control bits written to the status address
    localparam int unsigned CTRL_FLUSH   = 0;
    localparam int unsigned CTRL_CLR_OVF = 1;

    typedef logic [ENTRY_W-1:0] entry_t;

    function automatic entry_t pack_entry(logic [1:0] chan, logic rls, logic ext,
                                          logic [7:0] sc);
        entry_t e;
        e = '0;
        e[CHAN_LSB +: 2] = chan;
        e[RLS_BIT]       = rls;
        e[EXT_BIT]       = ext;
        e[SC_LSB +: 8]   = sc;
        return e;
    endfunction

    // Head fields are expected to be zeroed by the caller when the queue is empty
    function automatic logic [7:0] status_byte(logic nempty, logic ovf, logic full, entry_t head);
        logic [7:0] s;
        s = 8'h00;
        s[ST_NEMPTY]         = nempty;
        s[ST_OVF]            = ovf;
        s[ST_RLS]            = head[RLS_BIT];
        s[ST_EXT]            = head[EXT_BIT];
        s[ST_CHAN_LSB +: 2]  = head[CHAN_LSB +: 2];
        s[ST_FULL]           = full;
        return s;
    endfunction

endpackage

// File: rtl/ps2_evq_fifo.sv
// Synchronous FIFO of queue entries with push/pop/flush; push and pop may coincide even when full.
module ps2_evq_fifo
    import ps2_event_queue_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  entry_t              wdata,
    output entry_t              rdata,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    entry_t                mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push, do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot this push lands in
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointer and occupancy tracking; flush beats any push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
            else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
        end
    end

    // Storage array; contents are don't-care while the slot is not occupied
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ps2_event_queue.sv
// Multi-channel PS/2 event queue: per-channel holding registers, round-robin arbiter, FIFO,
// and the ZX-UNO data/status register pair used by the CPU to drain it.
module ps2_event_queue
    import ps2_event_queue_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter logic [7:0]  QDATA_ADDR   = QDATA_ADDR_DEF,
    parameter logic [7:0]  QSTATUS_ADDR = QSTATUS_ADDR_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     ev_valid,
    input  logic [8*NUM_CH-1:0]   ev_scancode,
    input  logic [NUM_CH-1:0]     ev_extended,
    input  logic [NUM_CH-1:0]     ev_released,
    input  logic [7:0]            zxuno_addr,
    input  logic                  zxuno_regrd,
    input  logic                  zxuno_regwr,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic                  oe,
    output logic                  irq
);

    logic [NUM_CH-1:0]   hold_v_q;
    entry_t              hold_data_q [NUM_CH];
    logic [1:0]          rr_q;
    logic                ovf_q;
    logic                rd_pend_q;

    logic                sel_data, sel_stat, flush, clr_ovf, pop, can_push;
    logic                gnt_any, ovf_evt, nempty;
    logic [1:0]          gnt_idx;
    entry_t              push_data, head, head_vis;
    logic                fifo_full, fifo_empty;
    logic [DEPTH_LOG2:0] fifo_count;
    logic [5:0]          unused_din;

    assign unused_din = din[7:2];
    assign sel_data   = (zxuno_addr == QDATA_ADDR);
    assign sel_stat   = (zxuno_addr == QSTATUS_ADDR);
    assign flush      = zxuno_regwr & sel_stat & din[CTRL_FLUSH];
    assign clr_ovf    = zxuno_regwr & sel_stat & din[CTRL_CLR_OVF];
    // One pop per data-read access, issued once the read strobe drops
    assign pop        = rd_pend_q & ~zxuno_regrd;
    assign can_push   = (~fifo_full | pop) & ~flush;
    assign nempty     = (fifo_count != '0);
    assign irq        = nempty;

    // Round-robin grant: first valid holding register at or after the priority pointer
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (can_push && !gnt_any && hold_v_q[c] &&
                    (c == (32'(rr_q) + off) % NUM_CH)) begin
                    gnt_any = 1'b1;
                    gnt_idx = 2'(c);
                end
            end
        end
    end

    // Select the granted holding register as FIFO write data
    always_comb begin
        push_data = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (gnt_idx == 2'(c)) push_data = hold_data_q[c];
        end
    end

    // An event is dropped when its holding register is full and not draining this cycle
    always_comb begin
        ovf_evt = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ev_valid[c] && hold_v_q[c] && !(gnt_any && gnt_idx == 2'(c)) && !flush) begin
                ovf_evt = 1'b1;
            end
        end
    end

    // Holding registers: load on strobe, reload when draining, clear on grant or flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v_q <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) hold_data_q[c] <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (flush) begin
                    hold_v_q[c] <= 1'b0;
                end else if (ev_valid[c] &&
                             (!hold_v_q[c] || (gnt_any && gnt_idx == 2'(c)))) begin
                    hold_v_q[c]    <= 1'b1;
                    hold_data_q[c] <= pack_entry(2'(c), ev_released[c], ev_extended[c],
                                                 ev_scancode[8*c +: 8]);
                end else if (gnt_any && gnt_idx == 2'(c)) begin
                    hold_v_q[c] <= 1'b0;
                end
            end
        end
    end

    // Priority pointer, sticky overflow flag and pending-pop tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= '0;
            ovf_q     <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            if (gnt_any) rr_q <= (gnt_idx == 2'(NUM_CH - 1)) ? 2'd0 : gnt_idx + 2'd1;
            ovf_q <= (ovf_q & ~clr_ovf) | ovf_evt;
            if (flush)            rd_pend_q <= 1'b0;
            else if (zxuno_regrd) rd_pend_q <= rd_pend_q | (sel_data & nempty);
            else                  rd_pend_q <= 1'b0;
        end
    end

    ps2_evq_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (gnt_any),
        .pop   (pop),
        .flush (flush),
        .wdata (push_data),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_vis = fifo_empty ? '0 : head;

    // Register read mux, combinational from state and bus inputs
    always_comb begin
        oe   = zxuno_regrd & (sel_data | sel_stat);
        dout = 8'h00;
        if (zxuno_regrd && sel_data)      dout = head_vis[SC_LSB +: 8];
        else if (zxuno_regrd && sel_stat) dout = status_byte(nempty, ovf_q, fifo_full, head_vis);
    end

endmodule

// File: tb/tb_ps2_event_queue.sv
// Bench for ps2_event_queue (3 channels, 4-entry FIFO): directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_ps2_event_queue;

    localparam int unsigned NCH   = 3;
    localparam int unsigned DL2   = 2;
    localparam int          DEPTH = 4;
    localparam logic [7:0]  A     = 8'h0A;
    localparam logic [7:0]  B     = 8'h0B;

    logic             clk, rst_n;
    logic [NCH-1:0]   ev_valid, ev_extended, ev_released;
    logic [8*NCH-1:0] ev_scancode;
    logic [7:0]       zxuno_addr, din, dout;
    logic             zxuno_regrd, zxuno_regwr, oe, irq;

    int checks   = 0;
    int failures = 0;

    ps2_event_queue #(
        .NUM_CH     (NCH),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ev_valid    (ev_valid),
        .ev_scancode (ev_scancode),
        .ev_extended (ev_extended),
        .ev_released (ev_released),
        .zxuno_addr  (zxuno_addr),
        .zxuno_regrd (zxuno_regrd),
        .zxuno_regwr (zxuno_regwr),
        .din         (din),
        .dout        (dout),
        .oe          (oe),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of entries, one slot per channel, sticky overflow
    logic [11:0] mq[$];
    bit          mhv[NCH];
    logic [11:0] mhd[NCH];
    int          mrr;
    bit          movf;
    bit          mpend;

    function automatic void model_reset();
        mq.delete();
        for (int c = 0; c < NCH; c++) begin
            mhv[c] = 0;
            mhd[c] = '0;
        end
        mrr   = 0;
        movf  = 0;
        mpend = 0;
    endfunction

    function automatic void model_step();
        int sz, g;
        bit fl, clr, pop, canp, ovf_set;
        logic [1:0] cc;
        sz      = mq.size();
        g       = -1;
        ovf_set = 0;
        fl   = zxuno_regwr && (zxuno_addr == B) && din[0];
        clr  = zxuno_regwr && (zxuno_addr == B) && din[1];
        pop  = mpend && !zxuno_regrd && (sz > 0);
        canp = ((sz < DEPTH) || pop) && !fl;
        if (canp)
            for (int k = 0; k < NCH; k++)
                if (g < 0 && mhv[(mrr + k) % NCH]) g = (mrr + k) % NCH;
        if (fl) mpend = 0;
        else if (zxuno_regrd) mpend = mpend || ((zxuno_addr == A) && (sz > 0));
        else mpend = 0;
        if (fl) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (g >= 0) begin
                mq.push_back(mhd[g]);
                mrr = (g + 1) % NCH;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            cc = 2'(c);
            if (fl) mhv[c] = 0;
            else if (ev_valid[c]) begin
                if (mhv[c] && g != c) ovf_set = 1;
                else begin
                    mhv[c] = 1;
                    mhd[c] = {cc, ev_released[c], ev_extended[c], ev_scancode[8*c +: 8]};
                end
            end else if (g == c) mhv[c] = 0;
        end
        movf = (movf && !clr) || ovf_set;
    endfunction

    function automatic logic [7:0] exp_dout();
        int sz;
        logic [11:0] h;
        sz = mq.size();
        h  = (sz != 0) ? mq[0] : 12'h000;
        if (!zxuno_regrd) return 8'h00;
        if (zxuno_addr == A) return h[7:0];
        if (zxuno_addr == B) return {sz != 0, movf, h[9], h[8], h[11:10], sz == DEPTH, 1'b0};
        return 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #2;
    endtask

    task automatic drive_idle();
        ev_valid    = '0;
        ev_extended = '0;
        ev_released = '0;
        ev_scancode = '0;
        zxuno_addr  = 8'h00;
        zxuno_regrd = 1'b0;
        zxuno_regwr = 1'b0;
        din         = 8'h00;
    endtask

    task automatic send(input int c, input logic [7:0] sc, input bit ext, input bit rls);
        ev_valid[c]           = 1'b1;
        ev_scancode[8*c +: 8] = sc;
        ev_extended[c]        = ext;
        ev_released[c]        = rls;
    endtask

    task automatic bus_read(input logic [7:0] a, input int ncyc, output logic [7:0] d,
                            output logic o);
        zxuno_addr  = a;
        zxuno_regrd = 1'b1;
        #1;
        d = dout;
        o = oe;
        repeat (ncyc) tick();
        zxuno_regrd = 1'b0;
        tick();
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] data);
        zxuno_addr  = a;
        zxuno_regwr = 1'b1;
        din         = data;
        tick();
        zxuno_regwr = 1'b0;
        din         = 8'h00;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %0b want 0", irq); end
        checks++; if (oe !== 1'b0) begin failures++; $display("FAIL reset_oe: got %0b want 0", oe); end
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout: got %02h want 00", dout); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        zxuno_addr  = B;
        zxuno_regrd = 1'b1;
        #1;
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_status: got %02h want 00", dout); end
        checks++; if (oe !== 1'b1) begin failures++; $display("FAIL reset_status_oe: got %0b want 1", oe); end
        zxuno_regrd = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] d;
        logic o;
        send(0, 8'h1C, 0, 0);
        tick();
        drive_idle();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL single_irq_early: got %0b want 0", irq); end
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL single_irq: got %0b want 1", irq); end
        bus_read(B, 1, d, o);
        checks++; if (d !== 8'h80) begin failures++; $display("FAIL single_status: got %02h want 80", d); end
        bus_read(A, 1, d, o);
        checks++; if (d !== 8'h1C) begin failures++; $display("FAIL single_data: got %02h want 1c", d); end
        checks++; if (o !== 1'b1) begin failures++; $display("FAIL single_oe: got %0b want 1", o); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL single_irq_after_pop: got %0b want 0", irq); end
    endtask

    task automatic test_simul();
        logic [7:0] d;
        logic o;
        apply_reset();
        send(0, 8'h12, 0, 0);
        send(1, 8'h5A, 0, 1);
        tick();
        drive_idle();
        tick();
        tick();
        bus_read(B, 1, d, o);
        checks++; if (d !== 8'h80) begin failures++; $display("FAIL simul_status0: got %02h want 80", d); end
        bus_read(A, 1, d, o);
        checks++; if (d !== 8'h12) begin failures++; $display("FAIL simul_data0: got %02h want 12", d); end
        bus_read(B, 1, d, o);
        checks++; if (d !== 8'hA4) begin failures++; $display("FAIL simul_status1: got %02h want a4", d); end
        bus_read(A, 1, d, o);
        checks++; if (d !== 8'h5A) begin failures++; $display("FAIL simul_data1: got %02h want 5a", d); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL simul_irq: got %0b want 0", irq); end
    endtask

    task automatic test_full_ovf();
        logic [7:0] d, want;
        logic o;
        for (int k = 0; k < 6; k++) begin
            send(0, 8'(8'h21 + k), 0, 0);
            tick();
            drive_idle();
            tick();
        end
        bus_read(B, 1, d, o);
        checks++; if (d !== 8'hC2) begin failures++; $display("FAIL full_status: got %02h want c2", d); end
        for (int k = 0; k < 5; k++) begin
            want = 8'(8'h21 + k);
            bus_read(A, 1, d, o);
            checks++; if (d !== want) begin failures++; $display("FAIL full_data%0d: got %02h want %02h", k, d, want); end
            if (k == 0) begin
                bus_read(B, 1, d, o);
                checks++; if (d !== 8'hC2) begin failures++; $display("FAIL full_refill_status: got %02h want c2", d); end
            end
        end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL full_irq: got %0b want 0", irq); end
        bus_read(B, 1, d, o);
        checks++; if (d !== 8'h40) begin failures++; $display("FAIL full_ovf_only: got %02h want 40", d); end
        bus_write(B, 8'h02);
        bus_read(B, 1, d, o);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL full_ovf_clear: got %02h want 00", d); end
    endtask

    task automatic test_multicycle();
        logic [7:0] d;
        logic o;
        send(2, 8'h33, 1, 0);
        tick();
        drive_idle();
        tick();
        send(2, 8'h44, 0, 0);
        tick();
        drive_idle();
        tick();
        bus_read(B, 1, d, o);
        checks++; if (d !== 8'h98) begin failures++; $display("FAIL multi_status0: got %02h want 98", d); end
        bus_read(A, 5, d, o);
        checks++; if (d !== 8'h33) begin failures++; $display("FAIL multi_data0: got %02h want 33", d); end
        bus_read(B, 1, d, o);
        checks++; if (d !== 8'h88) begin failures++; $display("FAIL multi_one_pop: got %02h want 88", d); end
        bus_read(A, 1, d, o);
        checks++; if (d !== 8'h44) begin failures++; $display("FAIL multi_data1: got %02h want 44", d); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL multi_irq: got %0b want 0", irq); end
    endtask

    task automatic test_empty_read();
        logic [7:0] d;
        logic o;
        bus_read(A, 1, d, o);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL empty_data: got %02h want 00", d); end
        checks++; if (o !== 1'b1) begin failures++; $display("FAIL empty_oe: got %0b want 1", o); end
        bus_read(8'h0C, 1, d, o);
        checks++; if (o !== 1'b0) begin failures++; $display("FAIL other_addr_oe: got %0b want 0", o); end
        send(1, 8'h77, 1, 1);
        tick();
        drive_idle();
        tick();
        bus_read(B, 1, d, o);
        checks++; if (d !== 8'hB4) begin failures++; $display("FAIL empty_then_push: got %02h want b4", d); end
        bus_read(A, 1, d, o);
        checks++; if (d !== 8'h77) begin failures++; $display("FAIL empty_then_data: got %02h want 77", d); end
    endtask

    task automatic test_flush();
        logic [7:0] d;
        logic o;
        send(0, 8'h01, 0, 0);
        send(1, 8'h02, 0, 0);
        tick();
        send(0, 8'h03, 0, 0);
        send(1, 8'h04, 0, 0);
        tick();
        drive_idle();
        tick();
        tick();
        bus_read(B, 1, d, o);
        checks++; if (d[7:6] !== 2'b11 || d[1] !== 1'b0) begin
            failures++; $display("FAIL flush_pre_status: got %02h want 11xxxx0x", d); end
        checks++; if (d !== exp_dout_after(d)) begin failures++; $display("FAIL flush_pre_model: got %02h", d); end
        zxuno_addr  = B;
        zxuno_regwr = 1'b1;
        din         = 8'h03;
        send(1, 8'h55, 0, 0);
        tick();
        drive_idle();
        zxuno_addr  = B;
        zxuno_regrd = 1'b1;
        #1;
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL flush_status: got %02h want 00", dout); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL flush_irq: got %0b want 0", irq); end
        zxuno_regrd = 1'b0;
        tick();
        tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL flush_discard: got %0b want 0", irq); end
    endtask

    // Status expected by the model for the queue state the previous read observed
    logic [7:0] snap_status;
    function automatic logic [7:0] exp_dout_after(input logic [7:0] unused_d);
        return snap_status;
    endfunction

    task automatic test_reset_mid();
        logic [7:0] d;
        logic o;
        apply_reset();
        send(0, 8'hA0, 0, 0);
        send(1, 8'hA1, 0, 0);
        tick();
        drive_idle();
        send(0, 8'hA2, 0, 0);
        tick();
        drive_idle();
        send(1, 8'hA3, 0, 0);
        tick();
        drive_idle();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL midrst_pre_irq: got %0b want 1", irq); end
        send(2, 8'hA4, 0, 0);
        zxuno_addr  = B;
        zxuno_regrd = 1'b1;
        rst_n       = 1'b0;
        model_reset();
        #1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL midrst_irq: got %0b want 0", irq); end
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL midrst_dout: got %02h want 00", dout); end
        tick();
        tick();
        drive_idle();
        rst_n = 1'b1;
        tick();
        checks++; if (oe !== 1'b0) begin failures++; $display("FAIL midrst_oe: got %0b want 0", oe); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL midrst_post_irq: got %0b want 0", irq); end
        send(1, 8'hB1, 0, 0);
        send(2, 8'hB2, 0, 0);
        tick();
        drive_idle();
        tick();
        bus_read(B, 1, d, o);
        checks++; if (d !== 8'h84) begin failures++; $display("FAIL midrst_rr_status: got %02h want 84", d); end
        bus_read(A, 1, d, o);
        checks++; if (d !== 8'hB1) begin failures++; $display("FAIL midrst_data0: got %02h want b1", d); end
        bus_read(B, 1, d, o);
        checks++; if (d !== 8'h88) begin failures++; $display("FAIL midrst_status1: got %02h want 88", d); end
        bus_read(A, 1, d, o);
        checks++; if (d !== 8'hB2) begin failures++; $display("FAIL midrst_data1: got %02h want b2", d); end
    endtask

    task automatic test_random();
        int rd_left, r;
        logic [7:0] want;
        rd_left = 0;
        drive_idle();
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < NCH; c++) ev_valid[c] = ($urandom_range(3) == 0);
            ev_scancode = 24'($urandom);
            ev_extended = 3'($urandom);
            ev_released = 3'($urandom);
            zxuno_regwr = 1'b0;
            din         = 8'h00;
            if (zxuno_regrd) begin
                if (rd_left == 0) zxuno_regrd = 1'b0;
                else rd_left--;
            end else begin
                r = $urandom_range(15);
                if (r < 5) begin
                    zxuno_regrd = 1'b1;
                    zxuno_addr  = (r < 3) ? A : ((r == 3) ? B : 8'h0C);
                    rd_left     = $urandom_range(2);
                end else if (r == 5) begin
                    zxuno_regwr = 1'b1;
                    zxuno_addr  = B;
                    din         = ($urandom_range(3) == 0) ? 8'h01 : 8'h02;
                end else if (r == 6) begin
                    zxuno_regwr = 1'b1;
                    zxuno_addr  = A;
                    din         = 8'($urandom);
                end
            end
            #1;
            want = exp_dout();
            checks++; if (dout !== want) begin failures++; $display("FAIL rand_dout cyc %0d: got %02h want %02h", n, dout, want); end
            checks++; if (oe !== (zxuno_regrd && (zxuno_addr == A || zxuno_addr == B))) begin
                failures++; $display("FAIL rand_oe cyc %0d: got %0b", n, oe); end
            checks++; if (irq !== (mq.size() != 0)) begin
                failures++; $display("FAIL rand_irq cyc %0d: got %0b want %0b", n, irq, mq.size() != 0); end
            tick();
        end
        drive_idle();
        tick();
    endtask

    // Snapshot model status ahead of the flush scenario's pre-check read
    always @(negedge clk) begin
        if (zxuno_regrd && zxuno_addr == B) snap_status = exp_dout();
    end

    initial begin
        snap_status = 8'h00;
        test_reset();
        test_single();
        test_simul();
        test_full_ovf();
        test_multicycle();
        test_empty_read();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_event_queue.md
# ps2_event_queue

Multi-channel PS/2 event queue that sits between the per-port PS/2 receivers (keyboard, mouse, extra ports) and the ZX-UNO register bus. It captures decoded key/byte events (scancode, extended, released, channel id) from up to four channels. Round-robin arbitration feeds them into one parametrised FIFO. The CPU drains the FIFO through two ZX-UNO registers, so no event is lost when software polls slower than the keyboard types.

## Interface
Parameters:
- NUM_CH, 2, number of event channels (1..4)
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (2..8)
- QDATA_ADDR, 8'h0A, ZX-UNO register address of the data port
- QSTATUS_ADDR, 8'h0B, ZX-UNO register address of the status/control port

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- ev_valid  in  NUM_CH  one-cycle event strobe per channel
- ev_scancode  in  8*NUM_CH  scancode, channel c at [8c+7:8c]
- ev_extended  in  NUM_CH  E0 prefix flag per channel
- ev_released  in  NUM_CH  F0 prefix flag per channel
- zxuno_addr  in  8  current register address
- zxuno_regrd  in  1  register read strobe (level, may last several cycles)
- zxuno_regwr  in  1  register write strobe
- din  in  8  CPU write data
- dout  out  8  read data, valid while oe=1
- oe  out  1  high when zxuno_regrd=1 and the address is QDATA_ADDR or QSTATUS_ADDR
- irq  out  1  high while the FIFO is non-empty

## Operation
- Entry is 12 bits: {chan[1:0], released, extended, scancode[7:0]}.
- Each channel has a one-entry holding register (hold_v, hold_data). ev_valid loads it at the clock edge.
- If hold_v is already 1 and is not being drained that cycle, the new event is dropped and OVF is set (sticky).
- If the holding register drains in the same cycle that a new event arrives, it reloads with the new event. No drop occurs.
- Arbiter: round-robin over channels with hold_v=1. Priority pointer starts at channel 0 and moves to granted+1 after each grant.
  - At most one grant per cycle, and only when the FIFO is not full.
  - When the FIFO is full, entries stay in their holding registers (backpressure).
- Read of QDATA: dout = head scancode; 8'h00 if empty.
- Read of QSTATUS: dout = {NEMPTY, OVF, head.released, head.extended, head.chan[1:0], FULL, 1'b0}. Head fields read 0 when empty.
- Pop: exactly one pop per QDATA read access. The pop happens on the first cycle in which zxuno_regrd is low after a QDATA read. Reading an empty FIFO does not pop.
- Write to QSTATUS:
  - din[0]=1 flushes the FIFO and all holding registers.
  - din[1]=1 clears OVF.
  - Both bits may be set together.
- Writes to QDATA are ignored.
- Simultaneous push and pop: both happen and count is unchanged. This includes the full case, since the pop frees a slot in the same cycle.
- Flush in the same cycle as a push or an incoming event: flush wins and the event is discarded. OVF is not set.
- Reset values: FIFO empty, all hold_v=0, OVF=0, RR pointer=0, dout=0, oe=0, irq=0.
- Reset asserted mid-operation clears all state immediately. No partial entry survives.

## Timing
- ev_valid sampled at edge t sets hold_v after edge t.
- Grant and FIFO write occur at edge t+1 when the FIFO is not full and the channel wins arbitration.
- The event is visible in NEMPTY/irq/dout after edge t+1.
- Latency is 2 cycles from strobe to visibility, plus 1 cycle per channel served ahead of it.
- dout and oe are combinational from registered state and the bus inputs, with no read wait states.
- Pop takes effect at the edge after zxuno_regrd falls. The next head is readable one cycle later.
- Throughput is 1 push/cycle and 1 pop per read access.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. Count is DEPTH_LOG2+1 bits:
  - FULL when count = 2**DEPTH_LOG2.
  - NEMPTY when count ≠ 0.

## Structure
- The shared package/config include holds QDATA/QSTATUS default addresses, the entry field offsets, and the status bit positions.
- Sub-module ps2_evq_fifo (parametrised synchronous FIFO: width 12, DEPTH_LOG2, push/pop/flush, full/empty/count).
- Arbiter and holding registers live in the top module.

## Test plan
- Single event: ch0 scancode 8'h1C, ext=0, rls=0 → after 2 cycles irq=1 and QSTATUS=8'h80. QDATA read returns 8'h1C; after regrd falls irq=0.
- Simultaneous ev_valid on ch0 (8'h12) and ch1 (8'h5A, rls=1) → FIFO order is ch0 then ch1. Second QSTATUS reads 8'hA4 (chan=1, rls=1).
- DEPTH_LOG2=2: push 6 events on ch0, one per 2 cycles, without reads → 4 queued, FULL=1. The fifth stays in holding, the sixth sets OVF. Reads return events 1–5 in order.
- Multi-cycle read: hold regrd on QDATA for 5 cycles → exactly one pop.
- Empty read → 8'h00, count stays 0.
- Write QSTATUS din=8'h03 with 3 queued, OVF=1, and a concurrent ev_valid → QSTATUS=8'h00 next cycle, and the concurrent event is discarded.
- Assert rst_n low mid-burst with 2 queued and both hold_v set → all outputs 0. After release, a new event is delivered normally starting from RR pointer 0.
